// File: rtl/kp_scan_ctrl_pkg.sv
// Shared definitions for the keypad scan controller.
//   KEY_W / ROWS / COLS : key code width and matrix geometry
//   kp_state_e          : scan/debounce state enumeration
//   low_row_idx()       : index of the lowest-numbered active-low row
package kp_pkg;

   localparam int KEY_W = 4;
   localparam int ROWS  = 4;
   localparam int COLS  = 4;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2,
      RELEASE  = 2'd3
   } kp_state_e;

   // Lowest index wins when several rows are pulled low together.
   function automatic logic [1:0] low_row_idx(input logic [ROWS-1:0] r);
      logic [1:0] idx;
      idx = '0;
      for (int unsigned i = ROWS; i > 0; i--) begin
         if (!r[i-1]) idx = 2'(i-1);
      end
      return idx;
   endfunction

endpackage

// File: rtl/kp_scan_ctrl_if.sv
// Keypad matrix + key-event bundle.
//   row       : keypad row lines, active-low, asynchronous
//   col       : column drive, active-low, one bit low
//   key_code  : row_idx*4 + col_idx of the accepted key
//   key_valid : one-cycle pulse on an accepted press
//   key_down  : high while the accepted key is held
//   latch_ena : strobe for the downstream negedge latch
// master = scan controller side, slave = keypad/consumer side.
interface kp_scan_ctrl_if;
   import kp_pkg::*;

   logic [ROWS-1:0]  row;
   logic [COLS-1:0]  col;
   logic [KEY_W-1:0] key_code;
   logic             key_valid;
   logic             key_down;
   logic             latch_ena;

   modport master (
      input  row,
      output col, key_code, key_valid, key_down, latch_ena
   );

   modport slave (
      output row,
      input  col, key_code, key_valid, key_down, latch_ena
   );

endinterface

// File: rtl/kp_scan_ctrl_tick_gen.sv
// Scan tick generator: free-running counter 0..SCAN_DIV-1, one-cycle
// tick while the counter sits at its terminal value.
//   clk  : clock
//   rst  : synchronous active-high reset (counter to 0)
//   tick : one pulse every SCAN_DIV clocks
module kp_tick_gen #(
   parameter int SCAN_DIV = 1000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (cnt == CW'(SCAN_DIV-1))
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

   assign tick = (cnt == CW'(SCAN_DIV-1));

endmodule

// File: rtl/kp_scan_ctrl.sv
// 4x4 keypad scan controller with press/release debounce.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : kp_scan_ctrl_if.master (row in; col, key_code, key_valid,
//         key_down, latch_ena out)
// Parameters: SCAN_DIV clocks per scan tick, DB_COUNT stable ticks to
// accept a press or release.
module kp_scan_ctrl
   import kp_pkg::*;
#(
   parameter int SCAN_DIV = 1000,
   parameter int DB_COUNT = 16
) (
   input  logic              clk,
   input  logic              rst,
   kp_scan_ctrl_if.master    bus
);

   localparam int DBW = $clog2(DB_COUNT + 1);

   logic             tick;
   logic [ROWS-1:0]  s1, rs;
   kp_state_e        state, state_nxt;
   logic [1:0]       col_idx, col_idx_nxt;
   logic [1:0]       cap_row, cap_row_nxt;
   logic [DBW-1:0]   db_cnt, db_nxt, db_inc;
   logic [KEY_W-1:0] code, code_nxt;
   logic             kv, kv_nxt;
   logic             le;
   logic             cap_low;

   kp_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign cap_low = ~rs[cap_row];
   // Saturating increment; the counter parks at DB_COUNT.
   assign db_inc  = (db_cnt >= DBW'(DB_COUNT)) ? db_cnt : db_cnt + DBW'(1);

   always_comb begin
      state_nxt   = state;
      col_idx_nxt = col_idx;
      cap_row_nxt = cap_row;
      db_nxt      = db_cnt;
      code_nxt    = code;
      kv_nxt      = 1'b0;
      if (tick) begin
         case (state)
            SCAN: begin
               if (rs == '1) begin
                  col_idx_nxt = col_idx + 2'd1;
               end else begin
                  cap_row_nxt = low_row_idx(rs);
                  db_nxt      = DBW'(1);
                  state_nxt   = DEBOUNCE;
               end
            end
            DEBOUNCE: begin
               if (cap_low) begin
                  db_nxt = db_inc;
                  if (db_inc == DBW'(DB_COUNT)) begin
                     state_nxt = PRESSED;
                     kv_nxt    = 1'b1;
                     code_nxt  = {cap_row, col_idx};
                  end
               end else begin
                  db_nxt      = '0;
                  col_idx_nxt = col_idx + 2'd1;
                  state_nxt   = SCAN;
               end
            end
            PRESSED: begin
               if (!cap_low) begin
                  db_nxt    = DBW'(1);
                  state_nxt = RELEASE;
               end
            end
            RELEASE: begin
               if (!cap_low) begin
                  db_nxt = db_inc;
                  if (db_inc == DBW'(DB_COUNT)) begin
                     col_idx_nxt = col_idx + 2'd1;
                     state_nxt   = SCAN;
                  end
               end else begin
                  db_nxt    = '0;
                  state_nxt = PRESSED;
               end
            end
            default: state_nxt = SCAN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1      <= '1;
         rs      <= '1;
         state   <= SCAN;
         col_idx <= '0;
         cap_row <= '0;
         db_cnt  <= '0;
         code    <= '0;
         kv      <= 1'b0;
         le      <= 1'b0;
      end else begin
         s1      <= bus.row;
         rs      <= s1;
         state   <= state_nxt;
         col_idx <= col_idx_nxt;
         cap_row <= cap_row_nxt;
         db_cnt  <= db_nxt;
         code    <= code_nxt;
         kv      <= kv_nxt;
         le      <= kv;
      end
   end

   assign bus.col       = ~(COLS'(1) << col_idx);
   assign bus.key_code  = code;
   assign bus.key_valid = kv;
   assign bus.latch_ena = le;
   assign bus.key_down  = (state == PRESSED) || (state == RELEASE);

endmodule

// File: tb/tb_kp_scan_ctrl.sv
// Directed bench for kp_scan_ctrl (SCAN_DIV=4, DB_COUNT=3). A keypad
// matrix model turns the pressed-key set plus the column drive into rows.
module tb_kp_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] keys = '0;
   int          nvec = 0;
   int          nerr = 0;
   int          vcnt = 0;
   int          lat_ok = 0;
   int          lat_bad = 0;
   int          col_bad = 0;
   logic        prev_kv = 1'b0;
   logic [1:0]  ph;

   kp_scan_ctrl_if bus ();

   kp_scan_ctrl #(.SCAN_DIV(4), .DB_COUNT(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Keypad matrix: row r is low if a held key (r,c) sits on a driven column.
   always_comb begin
      bus.row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !bus.col[c]) bus.row[r] = 1'b0;
   end

   // Bench copy of the scan phase: the tick edge is the one where ph leaves 3.
   always @(posedge clk) begin
      if (rst) ph <= '0;
      else     ph <= ph + 2'd1;
   end

   always @(negedge clk) begin
      if (bus.key_valid) vcnt++;
      if (bus.latch_ena) begin
         if (prev_kv) lat_ok++;
         else         lat_bad++;
      end
      prev_kv = bus.key_valid;
      if (!(bus.col inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) col_bad++;
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance through the next scan-tick edge, then settle to the negedge.
   task automatic tick_wait();
      logic [1:0] old;
      do begin
         @(posedge clk);
         old = ph;
      end while (old != 2'd3);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_col", 8'(bus.col), 8'hE);
      check("rst_kv", 8'(bus.key_valid), 8'h0);
      check("rst_code", 8'(bus.key_code), 8'h0);
      check("rst_kdown", 8'(bus.key_down), 8'h0);
      check("rst_latch", 8'(bus.latch_ena), 8'h0);
      rst = 1'b0;

      // Idle rotation
      tick_wait(); check("idle_col1", 8'(bus.col), 8'hD);
      tick_wait(); check("idle_col2", 8'(bus.col), 8'hB);
      tick_wait(); check("idle_col3", 8'(bus.col), 8'h7);
      tick_wait(); check("idle_col0", 8'(bus.col), 8'hE);
      check("idle_nokv", 8'(vcnt), 8'd0);

      // Key (row1,col2): col1, col2, detect, db2, accept
      keys[6] = 1'b1;
      repeat (4) tick_wait();
      check("p1_hold_col", 8'(bus.col), 8'hB);
      check("p1_pre_kv", 8'(bus.key_valid), 8'h0);
      tick_wait();
      check("p1_kv", 8'(bus.key_valid), 8'h1);
      check("p1_code", 8'(bus.key_code), 8'd6);
      check("p1_kdown", 8'(bus.key_down), 8'h1);
      check("p1_latch0", 8'(bus.latch_ena), 8'h0);
      @(negedge clk);
      check("p1_latch1", 8'(bus.latch_ena), 8'h1);
      check("p1_kv_off", 8'(bus.key_valid), 8'h0);
      @(negedge clk);
      check("p1_latch_off", 8'(bus.latch_ena), 8'h0);

      // Release bounce: high 2, low 1, high 3
      keys[6] = 1'b0;
      tick_wait(); check("rb_kd1", 8'(bus.key_down), 8'h1);
      tick_wait(); check("rb_kd2", 8'(bus.key_down), 8'h1);
      keys[6] = 1'b1;
      tick_wait(); check("rb_kd3", 8'(bus.key_down), 8'h1);
      keys[6] = 1'b0;
      tick_wait(); check("rb_kd4", 8'(bus.key_down), 8'h1);
      tick_wait(); check("rb_kd5", 8'(bus.key_down), 8'h1);
      check("rb_col_held", 8'(bus.col), 8'hB);
      tick_wait(); check("rb_kd_drop", 8'(bus.key_down), 8'h0);
      check("rb_col_adv", 8'(bus.col), 8'h7);
      check("rb_one_kv", 8'(vcnt), 8'd1);
      check("rb_code_hold", 8'(bus.key_code), 8'd6);

      // Press bounce on key (row2,col3): low 1, high 1, then steady low
      keys[11] = 1'b1;
      tick_wait(); check("pb_db_col", 8'(bus.col), 8'h7);
      keys[11] = 1'b0;
      tick_wait(); check("pb_abort_col", 8'(bus.col), 8'hE);
      keys[11] = 1'b1;
      repeat (3) tick_wait();
      check("pb_back_col", 8'(bus.col), 8'h7);
      repeat (2) tick_wait();
      check("pb_no_kv", 8'(vcnt), 8'd1);
      tick_wait();
      check("pb_kv", 8'(bus.key_valid), 8'h1);
      check("pb_code", 8'(bus.key_code), 8'd11);
      keys[11] = 1'b0;
      repeat (3) tick_wait();
      check("pb_rel_kd", 8'(bus.key_down), 8'h0);
      check("pb_rel_col", 8'(bus.col), 8'hE);

      // Reset mid-debounce on key (row1,col0) at db_cnt=2
      keys[4] = 1'b1;
      repeat (2) tick_wait();
      check("rd_db_kd", 8'(bus.key_down), 8'h0);
      rst = 1'b1;
      @(negedge clk);
      check("rd_col", 8'(bus.col), 8'hE);
      check("rd_kv", 8'(bus.key_valid), 8'h0);
      check("rd_code", 8'(bus.key_code), 8'h0);
      rst = 1'b0;
      repeat (2) tick_wait();
      check("rd_no_kv", 8'(vcnt), 8'd2);
      tick_wait();
      check("rd_kv_fresh", 8'(bus.key_valid), 8'h1);
      check("rd_code_fresh", 8'(bus.key_code), 8'd4);
      keys[4] = 1'b0;
      repeat (3) tick_wait();
      check("rd_rel_col", 8'(bus.col), 8'hD);

      // Two rows on col1: row 0 wins; row-1 activity while held is ignored
      keys[1] = 1'b1;
      keys[5] = 1'b1;
      repeat (3) tick_wait();
      check("mr_kv", 8'(bus.key_valid), 8'h1);
      check("mr_code", 8'(bus.key_code), 8'd1);
      keys[5] = 1'b0;
      tick_wait();
      check("mr_r1_up_kd", 8'(bus.key_down), 8'h1);
      keys[5] = 1'b1;
      tick_wait();
      check("mr_r1_dn_kv", 8'(vcnt), 8'd4);
      check("mr_code_hold", 8'(bus.key_code), 8'd1);
      keys = '0;
      repeat (3) tick_wait();
      check("mr_rel_kd", 8'(bus.key_down), 8'h0);
      check("mr_rel_code", 8'(bus.key_code), 8'd1);

      check("tot_kv", 8'(vcnt), 8'd4);
      check("tot_latch", 8'(lat_ok), 8'd4);
      check("latch_orphan", 8'(lat_bad), 8'd0);
      check("col_onehot", 8'(col_bad), 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
